alu_pipe_sequencer: RTL and testbench

// Issue-side sequencer for the 5-stage ALU pipeline. Accepts one instruction per cycle
// (valid/ready), shifts opcode + destination through stages S1..S5 and decodes per-stage
// ALU-op flags. Blocks issue on RAW hazards against in-flight ALU results, drives

---
 rtl/alu_pipe_sequencer_if.sv | 28 ++
 rtl/alu_pipe_sequencer.sv | 52 +++++
 tb/tb_alu_pipe_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_sequencer_if.sv
// alu_pipe_sequencer_if: issue handshake, flush and pipeline status bundle for the ALU sequencer
interface alu_pipe_sequencer_if #(
    parameter int OPW  = 7,
    parameter int REGW = 4,
    parameter int CNTW = 16
);
    logic              issue_valid;
    logic [OPW-1:0]    issue_op;
    logic [REGW-1:0]   issue_dst;
    logic [REGW-1:0]   issue_src_a;
    logic [REGW-1:0]   issue_src_b;
    logic              issue_ready;
    logic              flush;
    logic [5*OPW-1:0]  stage_op;
    logic [4:0]        alu_op;
    logic              wb_en;
    logic [REGW-1:0]   wb_dst;
    logic              busy;
    logic [CNTW-1:0]   retire_count;
    modport master (
        output issue_valid, issue_op, issue_dst, issue_src_a, issue_src_b, flush,
        input  issue_ready, stage_op, alu_op, wb_en, wb_dst, busy, retire_count
    );
    modport slave (
        input  issue_valid, issue_op, issue_dst, issue_src_a, issue_src_b, flush,
        output issue_ready, stage_op, alu_op, wb_en, wb_dst, busy, retire_count
    );
endinterface

// File: rtl/alu_pipe_sequencer.sv
// alu_pipe_sequencer: 5-stage ALU issue sequencer with RAW hazard blocking, S5 writeback and retire count
module alu_pipe_sequencer #(
    parameter int OPW     = 7,
    parameter int REGW    = 4,
    parameter int ALU_MAX = 10,
    parameter int CNTW    = 16
) (
    input logic clk,
    input logic rst_n,
    alu_pipe_sequencer_if.slave bus
);
    localparam logic [OPW-1:0] ALU_MAX_OP = OPW'(ALU_MAX);
    logic [4:0][OPW-1:0]  op_q, op_d;
    logic [4:0][REGW-1:0] dst_q, dst_d;
    logic [CNTW-1:0]      retire_q, retire_d;
    logic [4:0]           alu;
    logic                 hazard, ready, fire, wb;
    always_comb begin
        hazard = 1'b0;
        alu    = '0;
        for (int k = 0; k < 5; k++) begin
            alu[k] = (op_q[k] != '0) && (op_q[k] <= ALU_MAX_OP);
            hazard = hazard || (alu[k] && (dst_q[k] != '0) &&
                     (dst_q[k] == bus.issue_src_a || dst_q[k] == bus.issue_src_b));
        end
        // ready deliberately ignores issue_valid so the handshake has no combinational loop
        ready    = !hazard && !bus.flush;
        fire     = bus.issue_valid && ready;
        wb       = alu[4] && (dst_q[4] != '0);
        op_d     = bus.flush ? '0 : {op_q[3:0], (fire ? bus.issue_op : {OPW{1'b0}})};
        dst_d    = bus.flush ? '0 : {dst_q[3:0], (fire ? bus.issue_dst : {REGW{1'b0}})};
        retire_d = (wb && !(&retire_q)) ? retire_q + 1'b1 : retire_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            dst_q    <= '0;
            retire_q <= '0;
        end else begin
            op_q     <= op_d;
            dst_q    <= dst_d;
            retire_q <= retire_d;
        end
    end
    assign bus.issue_ready  = ready;
    assign bus.stage_op     = op_q;
    assign bus.alu_op       = alu;
    assign bus.wb_en        = wb;
    assign bus.wb_dst       = dst_q[4];
    assign bus.busy         = |op_q;
    assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_alu_pipe_sequencer.sv
// tb_alu_pipe_sequencer: vector table plus writeback scoreboard for the ALU pipe sequencer
module tb_alu_pipe_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic [15:0] exp_cnt = '0;
    typedef struct {
        logic [6:0] op;
        logic [3:0] dst;
        logic       alu;
        logic       wb;
    } vec_t;
    typedef struct {
        logic [3:0] dst;
        int         due;
    } sb_t;
    vec_t vt[8];
    sb_t  sbq[$];
    sb_t  e;
    alu_pipe_sequencer_if #(.OPW(7), .REGW(4), .CNTW(16)) bus ();
    alu_pipe_sequencer #(.OPW(7), .REGW(4), .ALU_MAX(10), .CNTW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_op    = '0;
        bus.issue_dst   = '0;
        bus.issue_src_a = '0;
        bus.issue_src_b = '0;
        bus.flush       = 1'b0;
    endtask
    task automatic offer(input logic [6:0] op, input logic [3:0] dst, input logic [3:0] sa, input logic [3:0] sb);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_dst   = dst;
        bus.issue_src_a = sa;
        bus.issue_src_b = sb;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_stage_op"}, bus.stage_op, 0);
        chk({tag, "_alu_op"}, bus.alu_op, 0);
        chk({tag, "_wb_en"}, bus.wb_en, 0);
        chk({tag, "_wb_dst"}, bus.wb_dst, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_retire"}, bus.retire_count, 0);
        chk({tag, "_ready"}, bus.issue_ready, 1);
    endtask
    always @(posedge clk) cyc++;
    always @(negedge rst_n) begin
        sbq.delete();
        exp_cnt = '0;
    end
    // Writeback scoreboard: checked on the falling edge, between register updates
    always @(negedge clk) begin
        if (rst_n) begin
            if (sbq.size() != 0 && sbq[0].due < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL wb_missing: no writeback seen, expected dst %0h at cycle %0d", sbq[0].dst, sbq[0].due);
                void'(sbq.pop_front());
            end
            if (bus.wb_en) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wb_unexpected: got wb_en=1 wb_dst=%0h, expected no writeback (cycle %0d)", bus.wb_dst, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_wb_dst", bus.wb_dst, e.dst);
                    chk("sb_wb_cycle", cyc, e.due);
                end
                chk("sb_retire_count", bus.retire_count, exp_cnt);
                if (exp_cnt != 16'hFFFF) exp_cnt++;
            end
            if (bus.flush) sbq.delete();
            else if (bus.issue_valid && bus.issue_ready && bus.issue_op != 0 && bus.issue_op <= 10 && bus.issue_dst != 0)
                sbq.push_back('{bus.issue_dst, cyc + 5});
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1);
    end
    initial begin
        vt[0] = '{7'd3,   4'd5,  1'b1, 1'b1};
        vt[1] = '{7'd12,  4'd5,  1'b0, 1'b0};
        vt[2] = '{7'd10,  4'd7,  1'b1, 1'b1};
        vt[3] = '{7'd11,  4'd7,  1'b0, 1'b0};
        vt[4] = '{7'd1,   4'd0,  1'b1, 1'b0};
        vt[5] = '{7'd0,   4'd0,  1'b0, 1'b0};
        vt[6] = '{7'd127, 4'd15, 1'b0, 1'b0};
        vt[7] = '{7'd2,   4'd15, 1'b1, 1'b1};
        idle();
        rst_n = 1'b0;
        #1;
        chk_reset("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            offer(vt[i].op, vt[i].dst, 4'd0, 4'd0);
            #1;
            chk("tbl_ready", bus.issue_ready, 1);
            step();
            idle();
            for (int k = 0; k < 5; k++) begin
                chk("tbl_alu_op", bus.alu_op, vt[i].alu ? (5'b00001 << k) : 5'b00000);
                chk("tbl_stage_op", bus.stage_op[k*7 +: 7], vt[i].op);
                chk("tbl_busy", bus.busy, vt[i].op != 0);
                if (k == 4) begin
                    chk("tbl_wb_en", bus.wb_en, vt[i].wb);
                    chk("tbl_wb_dst", bus.wb_dst, vt[i].dst);
                end
                step();
            end
            chk("tbl_drained", bus.busy, 0);
        end
        // RAW hazard: consumer of r5 held until the producer has written back
        offer(7'd3, 4'd5, 4'd0, 4'd0);
        #1;
        chk("raw_prod_ready", bus.issue_ready, 1);
        step();
        offer(7'd1, 4'd6, 4'd5, 4'd0);
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk("raw_stall", bus.issue_ready, 0);
            step();
        end
        chk("raw_release", bus.issue_ready, 1);
        step();
        idle();
        chk("raw_cons_s1", bus.stage_op[6:0], 7'd1);
        chk("raw_prod_gone", bus.stage_op[34:7], 0);
        repeat (6) step();
        // Non-ALU producer never blocks or writes back
        offer(7'd12, 4'd5, 4'd0, 4'd0);
        step();
        offer(7'd2, 4'd6, 4'd0, 4'd5);
        #1;
        chk("nonalu_no_stall", bus.issue_ready, 1);
        step();
        idle();
        chk("nonalu_alu_op_a", bus.alu_op, 5'b00001);
        repeat (3) step();
        chk("nonalu_alu_op_b", bus.alu_op, 5'b01000);
        chk("nonalu_no_wb", bus.wb_en, 0);
        step();
        chk("nonalu_alu_op_c", bus.alu_op, 5'b10000);
        chk("nonalu_wb", bus.wb_en, 1);
        chk("nonalu_wb_dst", bus.wb_dst, 6);
        step();
        chk("nonalu_drained", bus.busy, 0);
        // Flush with five ALU ops in flight
        for (int i = 1; i <= 5; i++) begin
            offer(7'd3, 4'(i), 4'd0, 4'd0);
            step();
        end
        idle();
        chk("flush_full", bus.alu_op, 5'b11111);
        chk("flush_s5_wb", bus.wb_en, 1);
        offer(7'd3, 4'd9, 4'd0, 4'd0);
        bus.flush = 1'b1;
        #1;
        chk("flush_ready", bus.issue_ready, 0);
        step();
        idle();
        chk("flush_busy", bus.busy, 0);
        chk("flush_stage_op", bus.stage_op, 0);
        chk("flush_alu_op", bus.alu_op, 0);
        for (int i = 0; i < 5; i++) begin
            chk("flush_no_wb", bus.wb_en, 0);
            step();
        end
        chk("flush_retire", bus.retire_count, exp_cnt);
        // Asynchronous reset mid-stream
        offer(7'd4, 4'd8, 4'd0, 4'd0);
        step();
        offer(7'd5, 4'd9, 4'd0, 4'd0);
        step();
        idle();
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_no_wb", bus.wb_en, 0);
        end
        // Saturation of the retire counter
        force dut.retire_q = 16'hFFFE;
        exp_cnt = 16'hFFFE;
        #1;
        release dut.retire_q;
        #1;
        chk("sat_preset", bus.retire_count, 16'hFFFE);
        for (int i = 2; i <= 4; i++) begin
            offer(7'd3, 4'(i), 4'd0, 4'd0);
            step();
        end
        idle();
        repeat (7) step();
        chk("sat_final", bus.retire_count, 16'hFFFF);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
